shake_input_arbiter: RTL and testbench
======================================

# shake_input_arbiter

Round-robin arbiter that shares the single SHAKE load stage between two requester streams. It locks the grant for one whole message by parsing the two-word message header and counting data words. It records the owner of each accepted message in a small FIFO so the squeeze/output side can route results back. It sits directly in front of the load stage: its `load_*` outputs drive the load stage's `valid_in`/`data_in`, and it consumes the load stage's `ready_out`.

## Interface
- `OWNER_DEPTH`, 4: owner FIFO entries; power of two, at least 2.
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `req0_valid` / `req1_valid`  in  1  requester word valid
- `req0_data` / `req1_data`  in  w  requester word (`w` from `keccak_pkg`)
- `req0_ready` / `req1_ready`  out  1  word accepted this cycle when valid&&ready
- `load_valid`  out  1  to load stage `valid_in`
- `load_data`  out  w  to load stage `data_in`
- `load_ready`  in  1  from load stage `ready_out`
- `result_done`  in  1  one-cycle pulse: oldest in-flight result fully drained
- `owner_valid`  out  1  owner FIFO non-empty
- `owner_id`  out  1  requester of the oldest in-flight message
- `busy`  out  1  state != IDLE

## Operation
- Message format: word0 = header (bits[31:0] output size, bits[33:32] mode); word1 = input size in bits (bits[31:0]); followed by ceil(size/w) data words. A message with size 0 has 2 words.
- States: IDLE, HDR0, HDR1, DATA.
- IDLE: if any reqN_valid and the owner FIFO is not full, register a grant and go to HDR0. Both valid: pick the requester `prio` points to. One valid: pick it. All `ready`/`load_valid` outputs are 0 in IDLE.
- Granted path is combinational: load_valid = reqG_valid; load_data = reqG_data; reqG_ready = load_ready. The non-granted ready is 0. When not granted, load_data = 0.
- Transfer = load_valid && load_ready.
- HDR0 transfer: push the grant id into the owner FIFO; go to HDR1.
- HDR1 transfer: load `remaining` = ceil(word1[31:0]/w). Width is 33 − log2(w) bits; compute as (size + w − 1) >> log2(w) in 33-bit arithmetic so 0xFFFFFFFF does not wrap. If the result is 0, complete the message; else go to DATA.
- DATA transfer: decrement `remaining`; the transfer with remaining==1 completes the message.
- Message complete: go to IDLE; `prio` ← the non-granted requester.
- Owner FIFO behaviour:
  - `result_done` pops it.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - `result_done` while empty is ignored.
  - A push while full cannot occur, because the grant is gated by not-full.
- Requester valid dropping mid-message stalls the message; the grant is held and no timeout applies.
- Reset mid-message: state → IDLE, FIFO empty, `prio` = 0. The partially forwarded message is abandoned; the load stage is reset by the same `rst`.

## Timing
- Reset values: all `reqN_ready` 0, `load_valid` 0, `load_data` 0, `owner_valid` 0, `owner_id` 0, `busy` 0, `prio` 0.
- Grant latency: a valid seen in IDLE at cycle t gives `load_valid` at t+1. The first word can transfer at t+1.
- Throughput: one word per cycle while granted and `load_ready`=1.
- Back-to-back messages: one IDLE bubble cycle between messages.
- `owner_valid`/`owner_id` update the cycle after the HDR0 transfer, and the cycle after a pop.

## Structure
- `keccak_pkg` additions:
  - `arb_state_t` enum (IDLE, HDR0, HDR1, DATA)
  - header field constants: `HDR_OUTSIZE_LSB`=0, `HDR_MODE_LSB`=32, `INSIZE_BITS`=32
- One sub-module `owner_fifo`:
  - parameterised depth, 1-bit data
  - push/pop/full/empty/head
  - pointer-based with wrap-around, occupancy counter of log2(DEPTH)+1 bits
- Arbiter FSM, `prio` register and `remaining` counter live in `shake_input_arbiter`.

## Test plan
- Single message on req0: header, size=200 (w=64) → 6 words forwarded unchanged; `owner_id`=0 valid from the cycle after the header; back to IDLE after the 6th transfer.
- Both requesters valid from reset, each sending size=64 → req0 first (3 words), one bubble, then req1; `owner_id` sequence 0,1. Repeat → order alternates.
- size=0 message → exactly 2 words forwarded; FSM goes HDR1→IDLE.
- `load_ready` toggled 1,0,1,0 plus req valid gaps mid-message → no duplicated or dropped words; the other requester stays not-ready throughout.
- Four messages without `result_done` (DEPTH=4) → 5th request is not granted (`busy`=0, readies 0); one `result_done` → grant next cycle. A simultaneous push and pop keeps occupancy constant.
- Assert `rst` during DATA → next cycle all outputs at reset values, `owner_valid`=0; a fresh message then completes normally.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared SHAKE types and constants.
// Holds the input arbiter state encoding and header field layout.
package keccak_pkg;

  localparam int W = 64;
  localparam int LOG2W = $clog2(W);
  localparam int HDR_OUTSIZE_LSB = 0;
  localparam int HDR_MODE_LSB = 32;
  localparam int INSIZE_BITS = 32;
  localparam int REM_W = 33 - LOG2W;

  typedef enum logic [1:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA
  } arb_state_t;

  // 33-bit sum so an all-ones size does not wrap
  function automatic logic [REM_W-1:0] words_for(
    input logic [INSIZE_BITS-1:0] bits
  );
    logic [32:0] s;
    s = {1'b0, bits} + 33'(W - 1);
    return REM_W'(s >> LOG2W);
  endfunction

endpackage

// File: rtl/shake_input_arbiter_if.sv
// Requester, load-stage and owner-tracking signals of the arbiter.
// master is the arbiter side, slave the surrounding logic.
interface shake_input_arbiter_if;
  import keccak_pkg::*;

  logic         req0_valid;
  logic [W-1:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_data;
  logic         req1_ready;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         result_done;
  logic         owner_valid;
  logic         owner_id;
  logic         busy;

  modport master (
    input  req0_valid, req0_data,
    input  req1_valid, req1_data,
    input  load_ready, result_done,
    output req0_ready, req1_ready,
    output load_valid, load_data,
    output owner_valid, owner_id, busy
  );

  modport slave (
    output req0_valid, req0_data,
    output req1_valid, req1_data,
    output load_ready, result_done,
    input  req0_ready, req1_ready,
    input  load_valid, load_data,
    input  owner_valid, owner_id, busy
  );

endinterface

// File: rtl/owner_fifo.sv
// Small 1-bit FIFO recording which requester owns each message.
module owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/shake_input_arbiter.sv
// Round-robin arbiter sharing the SHAKE load stage between two
// requesters, holding the grant for a whole parsed message.
module shake_input_arbiter
  import keccak_pkg::*;
#(
  parameter int OWNER_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  shake_input_arbiter_if.master bus
);

  arb_state_t       state;
  logic             gnt;
  logic             prio;
  logic [REM_W-1:0] remaining;
  logic [REM_W-1:0] nwords;
  logic             active;
  logic             xfer;
  logic             full;
  logic             empty;
  logic             head;
  logic             push;
  logic             any_req;

  assign active  = state != IDLE;
  assign xfer    = bus.load_valid && bus.load_ready;
  assign push    = state == HDR0 && xfer;
  assign any_req = bus.req0_valid || bus.req1_valid;
  assign nwords  = words_for(bus.load_data[INSIZE_BITS-1:0]);

  always_comb begin
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    if (active) begin
      if (gnt) begin
        bus.load_valid = bus.req1_valid;
        bus.load_data  = bus.req1_data;
        bus.req1_ready = bus.load_ready;
      end else begin
        bus.load_valid = bus.req0_valid;
        bus.load_data  = bus.req0_data;
        bus.req0_ready = bus.load_ready;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      prio      <= 1'b0;
      remaining <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req && !full) begin
            gnt <= (bus.req0_valid && bus.req1_valid)
                 ? prio : bus.req1_valid;
            state <= HDR0;
          end
        end
        HDR0: if (xfer) state <= HDR1;
        HDR1: begin
          if (xfer) begin
            remaining <= nwords;
            if (nwords == '0) begin
              state <= IDLE;
              prio  <= ~gnt;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            remaining <= remaining - 1'b1;
            if (remaining == REM_W'(1)) begin
              state <= IDLE;
              prio  <= ~gnt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  owner_fifo #(.DEPTH(OWNER_DEPTH)) u_owner (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (bus.result_done),
    .din   (gnt),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign bus.owner_valid = !empty;
  assign bus.owner_id    = !empty && head;
  assign bus.busy        = active;

endmodule

// File: tb/tb_shake_input_arbiter.sv
// Scoreboard bench for shake_input_arbiter.
module tb_shake_input_arbiter;
  import keccak_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   abort = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int           exp_own[$];
  int           exp_len[$];
  int           words_left = 0;
  int           cur = 0;

  always #5 clk = ~clk;

  shake_input_arbiter_if bus();

  shake_input_arbiter #(.OWNER_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      q0.delete();
      q1.delete();
      exp_own.delete();
      exp_len.delete();
      words_left = 0;
    end else begin
      check("dual_ready", bus.req0_ready & bus.req1_ready, 0);
      if (bus.load_valid && bus.load_ready) begin
        if (words_left == 0) begin
          if (exp_own.size() == 0) begin
            check("unexp_xfer", 1, 0);
          end else begin
            cur = exp_own.pop_front();
            words_left = exp_len.pop_front();
          end
        end
        if (words_left > 0) begin
          check("src_ready", cur ? bus.req1_ready : bus.req0_ready, 1);
          e = '0;
          if (cur != 0 && q1.size() > 0) e = q1.pop_front();
          if (cur == 0 && q0.size() > 0) e = q0.pop_front();
          check("load_data", bus.load_data, e);
          words_left--;
        end
      end
    end
  end

  function automatic logic [W-1:0] hdr(input bit id,
                                       input logic [31:0] sz);
    return {30'b0, id ? 2'b10 : 2'b01, 32'h100 + sz};
  endfunction

  task automatic drive(input bit id, input bit v, input logic [W-1:0] d);
    if (id) begin
      bus.req1_valid = v;
      bus.req1_data  = d;
    end else begin
      bus.req0_valid = v;
      bus.req0_data  = d;
    end
  endtask

  task automatic send(input bit id, input logic [31:0] size,
                      input bit gaps);
    logic [W-1:0] words[$];
    int n;
    int t;
    bit r;
    n = int'((longint'(size) + 63) / 64);
    words.push_back(hdr(id, size));
    words.push_back(W'(size));
    for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom});
    foreach (words[i]) begin
      if (id) q1.push_back(words[i]);
      else q0.push_back(words[i]);
    end
    foreach (words[i]) begin
      drive(id, 1'b1, words[i]);
      t = 0;
      forever begin
        @(negedge clk);
        r = id ? bus.req1_ready : bus.req0_ready;
        @(posedge clk);
        #1;
        if (abort) begin
          drive(id, 1'b0, '0);
          return;
        end
        if (r) break;
        t++;
        if (t > 300) begin
          check("send_timeout", 1, 0);
          drive(id, 1'b0, '0);
          return;
        end
      end
      if (gaps && i % 2 == 0) begin
        drive(id, 1'b0, '0);
        @(posedge clk);
        #1;
      end
    end
    drive(id, 1'b0, '0);
  endtask

  task automatic expect_msg(input int id, input int len);
    exp_own.push_back(id);
    exp_len.push_back(len);
  endtask

  task automatic pop_owner(input bit id);
    @(negedge clk);
    check("owner_valid", bus.owner_valid, 1);
    check("owner_id", bus.owner_id, id);
    bus.result_done = 1'b1;
    @(posedge clk);
    #1;
    bus.result_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_r0"}, bus.req0_ready, 0);
    check({tag, "_r1"}, bus.req1_ready, 0);
    check({tag, "_lv"}, bus.load_valid, 0);
    check({tag, "_ld"}, bus.load_data, 0);
    check({tag, "_ov"}, bus.owner_valid, 0);
    check({tag, "_oid"}, bus.owner_id, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit toggling;
    int t;
    bus.req0_valid  = 1'b0;
    bus.req0_data   = '0;
    bus.req1_valid  = 1'b0;
    bus.req1_data   = '0;
    bus.load_ready  = 1'b1;
    bus.result_done = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single 200-bit message on req0: 6 words
    expect_msg(0, 6);
    send(0, 200, 0);
    @(negedge clk);
    check("t1_idle", bus.busy, 0);
    pop_owner(0);
    @(negedge clk);
    check("t1_empty", bus.owner_valid, 0);

    // both requesters from reset, twice
    do_reset();
    repeat (2) begin
      expect_msg(0, 3);
      expect_msg(1, 3);
      fork
        send(0, 64, 0);
        send(1, 64, 0);
      join
      pop_owner(0);
      pop_owner(1);
    end

    // empty message
    expect_msg(1, 2);
    send(1, 0, 0);
    @(negedge clk);
    check("t3_idle", bus.busy, 0);

    // backpressure and valid gaps
    expect_msg(0, 6);
    expect_msg(1, 3);
    toggling = 1'b1;
    fork
      begin
        fork
          send(0, 256, 1);
          send(1, 64, 0);
        join
        toggling = 1'b0;
      end
      while (toggling) begin
        @(posedge clk);
        #1;
        bus.load_ready = ~bus.load_ready;
      end
    join
    bus.load_ready = 1'b1;
    pop_owner(1);
    pop_owner(0);
    pop_owner(1);

    // fill owner FIFO
    repeat (4) begin
      expect_msg(0, 2);
      send(0, 0, 0);
    end
    expect_msg(0, 2);
    fork
      send(0, 0, 0);
      begin
        repeat (3) @(negedge clk);
        check("full_busy", bus.busy, 0);
        check("full_ready", bus.req0_ready, 0);
        check("full_lv", bus.load_valid, 0);
        bus.result_done = 1'b1;
        @(posedge clk);
        #1;
        bus.result_done = 1'b0;
        @(negedge clk);
        check("pop_nogrant", bus.busy, 0);
        @(negedge clk);
        check("pop_grant", bus.busy, 1);
      end
    join
    pop_owner(0);
    expect_msg(1, 2);
    fork
      send(1, 0, 0);
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!bus.req1_ready && t < 50);
        check("pp_seen", bus.req1_ready, 1);
        bus.result_done = 1'b1;
        @(posedge clk);
        #1;
        bus.result_done = 1'b0;
      end
    join
    pop_owner(0);
    pop_owner(0);
    pop_owner(1);
    @(negedge clk);
    check("pp_empty", bus.owner_valid, 0);

    // reset in the middle of DATA
    expect_msg(0, 12);
    fork
      send(0, 640, 0);
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!(words_left > 0 && words_left <= 6) && t < 100);
        check("mid_data", bus.busy, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("mrst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        abort = 1'b0;
      end
    join
    expect_msg(1, 4);
    send(1, 128, 0);
    @(negedge clk);
    check("t7_idle", bus.busy, 0);
    pop_owner(1);
    @(negedge clk);
    check("t7_empty", bus.owner_valid, 0);
    check("sb_empty", q0.size() + q1.size() + exp_own.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
